issue_scoreboard: RTL

Parametrised register scoreboard and hazard controller for the in-order pipeline and its variable-latency successors. It sits between decode and execute, tracks a countdown of cycles until each architectural register's pending result reaches writeback, and produces the issue stall and writeback-bypass selects. Unlike the fixed 5-stage hazard check, it supports per-instruction result latency, WAW ordering, and partial flush.

---
 rtl/issue_scoreboard_if.sv | 35 +++
 rtl/issue_scoreboard.sv | 103 ++++++++++
 2 files changed

// File: rtl/issue_scoreboard_if.sv
// Issue-side bus between decode and the register scoreboard.
// The master (decode) drives the instruction and flush; the slave returns stall, ack, bypass selects and busy.
interface issue_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3
);
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic                  issue_rs1_used;
  logic                  issue_rs2_used;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_rd_wen;
  logic [LAT_W-1:0]      issue_lat;
  logic                  flush;
  logic [LAT_W-1:0]      flush_keep;
  logic                  stall;
  logic                  issue_ack;
  logic                  fwd1_sel;
  logic                  fwd2_sel;
  logic [NUM_REGS-1:0]   busy;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_wen, issue_lat, flush, flush_keep,
    input  stall, issue_ack, fwd1_sel, fwd2_sel, busy
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_wen, issue_lat, flush, flush_keep,
    output stall, issue_ack, fwd1_sel, fwd2_sel, busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Per-register writeback countdown producing issue stall, ack and bypass selects; SCOREBOARD_BYPASS_EN enables forwarding.
// stall/ack/fwd are combinational (0 cycles), busy is registered; decode holds the instruction while stall is high.
module issue_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 7,
  parameter int LAT_W      = 3
) (
  input logic               clk,
  input logic               reset,
  issue_scoreboard_if.slave sb
);

  localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] ONE_C     = LAT_W'(1);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;

  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] rs1_cnt;
  logic [LAT_W-1:0] rs2_cnt;
  logic [LAT_W-1:0] rd_cnt;
  logic             rs1_chk;
  logic             rs2_chk;
  logic             haz1;
  logic             haz2;
  logic             fwd1;
  logic             fwd2;
  logic             waw;
  logic             stall_c;
  logic             ack_c;
  logic             wr_en;
  logic [NUM_REGS-1:0] busy_c;

  // Mux-style lookup so addresses beyond NUM_REGS and register 0 read as idle.
  function automatic logic [LAT_W-1:0] cnt_of(
    input logic [REG_ADDR_W-1:0]          a,
    input logic [NUM_REGS-1:0][LAT_W-1:0] c
  );
    logic [LAT_W-1:0] v;
    v = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (a == REG_ADDR_W'(r)) v = c[r];
    end
    return v;
  endfunction

  always_comb begin
    lat_eff = (sb.issue_lat > MAX_LAT_C) ? MAX_LAT_C : sb.issue_lat;
    rs1_chk = sb.issue_rs1_used && (sb.issue_rs1 != '0);
    rs2_chk = sb.issue_rs2_used && (sb.issue_rs2 != '0);
    rs1_cnt = cnt_of(sb.issue_rs1, cnt);
    rs2_cnt = cnt_of(sb.issue_rs2, cnt);
    rd_cnt  = cnt_of(sb.issue_rd, cnt);
`ifdef SCOREBOARD_BYPASS_EN
    haz1 = rs1_chk && (rs1_cnt > ONE_C);
    haz2 = rs2_chk && (rs2_cnt > ONE_C);
    fwd1 = rs1_chk && (rs1_cnt == ONE_C);
    fwd2 = rs2_chk && (rs2_cnt == ONE_C);
`else
    haz1 = rs1_chk && (rs1_cnt != '0);
    haz2 = rs2_chk && (rs2_cnt != '0);
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
    // A zero latency result is already written, so it can neither conflict nor be tracked.
    waw     = sb.issue_rd_wen && (sb.issue_rd != '0) && (lat_eff != '0) && (rd_cnt >= lat_eff);
    stall_c = sb.issue_valid && (haz1 || haz2 || waw);
    ack_c   = reset && sb.issue_valid && !stall_c && !sb.flush;
    wr_en   = ack_c && sb.issue_rd_wen && (sb.issue_rd != '0) && (lat_eff != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_en && (sb.issue_rd == REG_ADDR_W'(r))) begin
          cnt[r] <= lat_eff;
        end else if (sb.flush && (cnt[r] > sb.flush_keep)) begin
          cnt[r] <= '0;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - ONE_C;
        end
      end
    end
  end

  always_comb begin
    busy_c = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_c[r] = (cnt[r] != '0);
    end
  end

  assign sb.stall     = stall_c;
  assign sb.issue_ack = ack_c;
  assign sb.fwd1_sel  = fwd1;
  assign sb.fwd2_sel  = fwd2;
  assign sb.busy      = busy_c;

endmodule
